// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module  : game_pkg
// Brief   : Shared types, screen geometry and geometry helpers for the shooter.
// Revision: 1.0
// ============================================================================
package game_pkg;

  localparam int COORD_W  = 10;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLAYING   = 3'd1,
    ST_PAUSED    = 3'd2,
    ST_HIT       = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;

  // One extra bit so the difference never wraps.
  function automatic logic [COORD_W:0] abs_diff(input coord_t a, input coord_t b);
    return (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
  endfunction

endpackage
`default_nettype wire

// File: rtl/game_if.sv
`default_nettype none
// ============================================================================
// Module  : game_if
// Brief   : Game-side signal bundle: controls, ship/ally geometry, enemy shot, HUD.
// Revision: 1.0
// ============================================================================
interface game_if;
  import game_pkg::*;

  logic        start;
  logic        pausa;
  coord_t      x_nave;
  coord_t      y_nave;
  coord_t      largura_nave;
  coord_t      altura_nave;
  coord_t      x_bola_aliada;
  coord_t      y_bola_aliada;
  coord_t      raio_bola_aliada;
  coord_t      x_bola_inimiga;
  coord_t      y_bola_inimiga;
  coord_t      raio_bola_inimiga;
  logic        reiniciarJogo;
  logic        perdeu;
  logic [9:0]  score;
  logic [1:0]  vidas;
  logic [2:0]  estado;

  modport master (
    output start, pausa, x_nave, y_nave, largura_nave, altura_nave,
           x_bola_aliada, y_bola_aliada, raio_bola_aliada,
    input  x_bola_inimiga, y_bola_inimiga, raio_bola_inimiga,
           reiniciarJogo, perdeu, score, vidas, estado
  );

  modport slave (
    input  start, pausa, x_nave, y_nave, largura_nave, altura_nave,
           x_bola_aliada, y_bola_aliada, raio_bola_aliada,
    output x_bola_inimiga, y_bola_inimiga, raio_bola_inimiga,
           reiniciarJogo, perdeu, score, vidas, estado
  );
endinterface
`default_nettype wire

// File: rtl/game_controller_frame_ticker.sv
`default_nettype none
// ============================================================================
// Module  : frame_ticker
// Brief   : Free-running divider; tick is high on the cycle the counter wraps.
// Revision: 1.0
// ============================================================================
module frame_ticker #(
  parameter int TICK_DIV = 833333
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] c_last = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_count <= '0;
    else if (r_count == c_last)
      r_count <= '0;
    else
      r_count <= r_count + 1'b1;
  end

  assign tick = (r_count == c_last);
endmodule
`default_nettype wire

// File: rtl/game_controller.sv
`default_nettype none
// ============================================================================
// Module  : game_controller
// Brief   : Game sequencer: state machine, enemy shot, collisions, score, lives.
// Revision: 1.0
// ============================================================================
module game_controller
  import game_pkg::*;
#(
  parameter int TICK_DIV     = 833333,
  parameter int ENEMY_SPEED  = 2,
  parameter int ENEMY_RADIUS = 5,
  parameter int SPAWN_Y      = 20,
  parameter int FLOOR_Y      = 470,
  parameter int LIVES_INIT   = 3,
  parameter int HIT_FRAMES   = 30
) (
  input  logic  CLOCK_50,
  input  logic  reset,
  game_if.slave bus
);
  localparam int HW = $clog2(HIT_FRAMES + 1);
  localparam logic [COORD_W:0] c_radius  = 11'(ENEMY_RADIUS);
  localparam logic [COORD_W:0] c_speed   = 11'(ENEMY_SPEED);
  localparam logic [COORD_W:0] c_floor   = 11'(FLOOR_Y);
  localparam coord_t           c_spawn_y = 10'(SPAWN_Y);
  localparam logic [1:0]       c_lives   = 2'(LIVES_INIT);
  localparam logic [HW-1:0]    c_hit_end = HW'(HIT_FRAMES - 1);

  state_t        r_state, w_state_n;
  logic [9:0]    r_score, w_score_n;
  logic [1:0]    r_vidas, w_vidas_n;
  coord_t        r_x, w_x_n, r_y, w_y_n;
  logic [HW-1:0] r_hit_cnt, w_hit_cnt_n;
  logic          r_restart, w_restart_n;
  logic [9:0]    r_lfsr;
  logic          w_tick;

  frame_ticker #(.TICK_DIV(TICK_DIV)) u_ticker (
    .clk   (CLOCK_50),
    .rst_n (reset),
    .tick  (w_tick)
  );

  // Ship test uses the enemy bounding box; the low edge clamps at 0.
  logic [COORD_W:0] w_ex_lo, w_ex_hi, w_ey_lo, w_ey_hi, w_rsum, w_y_step;
  logic             w_ship_hit, w_ally_hit;
  coord_t           w_spawn_x;

  always_comb begin
    w_ex_hi  = {1'b0, r_x} + c_radius;
    w_ey_hi  = {1'b0, r_y} + c_radius;
    w_ex_lo  = ({1'b0, r_x} >= c_radius) ? ({1'b0, r_x} - c_radius) : '0;
    w_ey_lo  = ({1'b0, r_y} >= c_radius) ? ({1'b0, r_y} - c_radius) : '0;
    w_ship_hit = (w_ex_hi >= {1'b0, bus.x_nave}) &&
                 (w_ex_lo <  ({1'b0, bus.x_nave} + {1'b0, bus.largura_nave})) &&
                 (w_ey_hi >= {1'b0, bus.y_nave}) &&
                 (w_ey_lo <  ({1'b0, bus.y_nave} + {1'b0, bus.altura_nave}));
    w_rsum     = {1'b0, bus.raio_bola_aliada} + c_radius;
    w_ally_hit = (bus.raio_bola_aliada != '0) &&
                 (abs_diff(r_x, bus.x_bola_aliada) <= w_rsum) &&
                 (abs_diff(r_y, bus.y_bola_aliada) <= w_rsum);
    w_y_step   = {1'b0, r_y} + c_speed;
    w_spawn_x  = {1'b0, r_lfsr[8:0]} + 10'd64;
  end

  always_comb begin
    w_state_n   = r_state;
    w_score_n   = r_score;
    w_vidas_n   = r_vidas;
    w_x_n       = r_x;
    w_y_n       = r_y;
    w_hit_cnt_n = r_hit_cnt;
    w_restart_n = 1'b0;
    case (r_state)
      ST_IDLE, ST_GAME_OVER: begin
        if (bus.start) begin
          w_state_n   = ST_PLAYING;
          w_score_n   = '0;
          w_vidas_n   = c_lives;
          w_x_n       = w_spawn_x;
          w_y_n       = c_spawn_y;
          w_restart_n = 1'b1;
        end
      end
      ST_PLAYING: begin
        // A pause request wins over a coincident frame tick.
        if (bus.pausa) begin
          w_state_n = ST_PAUSED;
        end else if (w_tick) begin
          if (w_ship_hit) begin
            w_vidas_n   = r_vidas - 2'd1;
            w_x_n       = w_spawn_x;
            w_y_n       = c_spawn_y;
            w_hit_cnt_n = '0;
            w_state_n   = (r_vidas == 2'd1) ? ST_GAME_OVER : ST_HIT;
          end else if (w_ally_hit) begin
            w_score_n = (r_score == 10'd999) ? r_score : r_score + 10'd1;
            w_x_n     = w_spawn_x;
            w_y_n     = c_spawn_y;
          end else if (w_y_step >= c_floor) begin
            w_x_n = w_spawn_x;
            w_y_n = c_spawn_y;
          end else begin
            w_y_n = w_y_step[COORD_W-1:0];
          end
        end
      end
      ST_PAUSED: begin
        if (!bus.pausa) w_state_n = ST_PLAYING;
      end
      ST_HIT: begin
        if (w_tick) begin
          if (r_hit_cnt == c_hit_end) w_state_n = ST_PLAYING;
          else                         w_hit_cnt_n = r_hit_cnt + 1'b1;
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_score   <= '0;
      r_vidas   <= c_lives;
      r_x       <= '0;
      r_y       <= c_spawn_y;
      r_hit_cnt <= '0;
      r_restart <= 1'b0;
      r_lfsr    <= 10'h3FF;
    end else begin
      r_state   <= w_state_n;
      r_score   <= w_score_n;
      r_vidas   <= w_vidas_n;
      r_x       <= w_x_n;
      r_y       <= w_y_n;
      r_hit_cnt <= w_hit_cnt_n;
      r_restart <= w_restart_n;
      r_lfsr    <= {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
    end
  end

  assign bus.x_bola_inimiga    = r_x;
  assign bus.y_bola_inimiga    = r_y;
  assign bus.raio_bola_inimiga = (r_state == ST_PLAYING || r_state == ST_PAUSED)
                                 ? c_radius[COORD_W-1:0] : '0;
  assign bus.reiniciarJogo     = r_restart;
  assign bus.perdeu            = (r_state == ST_GAME_OVER);
  assign bus.score             = r_score;
  assign bus.vidas             = r_vidas;
  assign bus.estado            = r_state;
endmodule
`default_nettype wire

// File: tb/tb_game_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_game_controller
// Brief   : Directed, table-driven bench for game_controller (TICK_DIV=4, HIT_FRAMES=3).
// Revision: 1.0
// ============================================================================
module tb_game_controller;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  game_if bus ();

  game_controller #(.TICK_DIV(4), .HIT_FRAMES(3)) dut (
    .CLOCK_50 (clk),
    .reset    (reset_n),
    .bus      (bus)
  );

  // Reference frame counter and LFSR, both restarted by the async reset.
  int         m_cnt;
  logic [9:0] m_lfsr;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_cnt  <= 0;
      m_lfsr <= 10'h3FF;
    end else begin
      m_cnt  <= (m_cnt == 3) ? 0 : m_cnt + 1;
      m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
    end
  end

  int checks = 0;
  int failures = 0;
  int exp_x, exp_y, exp_score, exp_vidas, pred_x;

  typedef struct {
    int ally_dx;
    int ally_dy;
    int ally_r;
    bit ship_near;
    int ship_dx;
    bit exp_score;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic ship_far();
    bus.x_nave = 10'd620; bus.y_nave = 10'd0;
    bus.largura_nave = 10'd10; bus.altura_nave = 10'd10;
  endtask

  task automatic ship_on_enemy();
    bus.x_nave = 10'(exp_x - 10); bus.y_nave = 10'(exp_y - 10);
    bus.largura_nave = 10'd20; bus.altura_nave = 10'd20;
  endtask

  task automatic ally_at(input int dx, input int dy, input int r);
    bus.x_bola_aliada = 10'(exp_x + dx);
    bus.y_bola_aliada = 10'(exp_y + dy);
    bus.raio_bola_aliada = 10'(r);
  endtask

  // Run up to and through the next frame tick; pred_x is the spawn x for that edge.
  task automatic do_tick();
    int guard = 0;
    @(negedge clk);
    while (m_cnt != 3 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 10) begin
      checks++; failures++;
      $display("FAIL tick_wait: got no tick expected tick within 10 cycles");
    end
    pred_x = int'(m_lfsr[8:0]) + 64;
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    pred_x = int'(m_lfsr[8:0]) + 64;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic chk_pos(input string tag);
    chk({tag, "_x"}, int'(bus.x_bola_inimiga), exp_x);
    chk({tag, "_y"}, int'(bus.y_bola_inimiga), exp_y);
  endtask

  initial begin
    bus.start = 1'b0; bus.pausa = 1'b0;
    ship_far();
    bus.x_bola_aliada = '0; bus.y_bola_aliada = '0; bus.raio_bola_aliada = '0;

    //            dx  dy  r  ship dx  score
    vecs[0] = '{  0,  0, 3, 1'b0,  0, 1'b1};
    vecs[1] = '{  0,  0, 0, 1'b0,  0, 1'b0};
    vecs[2] = '{  8,  0, 3, 1'b0,  0, 1'b1};
    vecs[3] = '{  9,  0, 3, 1'b0,  0, 1'b0};
    vecs[4] = '{  0, -8, 3, 1'b0,  0, 1'b1};
    vecs[5] = '{ -9,  0, 3, 1'b0,  0, 1'b0};
    vecs[6] = '{  0,  0, 0, 1'b1,  6, 1'b0};
    vecs[7] = '{  0,  0, 0, 1'b1,-25, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_estado", int'(bus.estado), 0);
    chk("rst_score", int'(bus.score), 0);
    chk("rst_vidas", int'(bus.vidas), 3);
    chk("rst_x", int'(bus.x_bola_inimiga), 0);
    chk("rst_y", int'(bus.y_bola_inimiga), 20);
    chk("rst_raio", int'(bus.raio_bola_inimiga), 0);
    chk("rst_perdeu", int'(bus.perdeu), 0);
    chk("rst_reinic", int'(bus.reiniciarJogo), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Start
    pulse_start();
    exp_x = pred_x; exp_y = 20; exp_score = 0; exp_vidas = 3;
    chk("start_reinic", int'(bus.reiniciarJogo), 1);
    chk("start_estado", int'(bus.estado), 1);
    chk("start_vidas", int'(bus.vidas), 3);
    chk("start_score", int'(bus.score), 0);
    chk_pos("start");
    chk("start_raio", int'(bus.raio_bola_inimiga), 5);
    @(posedge clk); #1;
    chk("start_reinic_drop", int'(bus.reiniciarJogo), 0);

    // Fall 10 ticks, then down to the floor
    repeat (10) do_tick();
    exp_y = 40;
    chk_pos("fall10");
    repeat (214) do_tick();
    exp_y = 468;
    chk_pos("fall468");
    do_tick();
    exp_x = pred_x; exp_y = 20;
    chk_pos("floor");
    chk("floor_xrange", int'(bus.x_bola_inimiga >= 10'd64 && bus.x_bola_inimiga <= 10'd575), 1);
    chk("floor_vidas", int'(bus.vidas), 3);

    // Table: ally / ship boundary cases
    for (int i = 0; i < 8; i++) begin
      ally_at(vecs[i].ally_dx, vecs[i].ally_dy, vecs[i].ally_r);
      if (vecs[i].ship_near) begin
        bus.x_nave = 10'(exp_x + vecs[i].ship_dx); bus.y_nave = 10'(exp_y - 10);
        bus.largura_nave = 10'd20; bus.altura_nave = 10'd20;
      end else ship_far();
      do_tick();
      if (vecs[i].exp_score) begin
        exp_score++; exp_x = pred_x; exp_y = 20;
      end else exp_y += 2;
      chk($sformatf("vec%0d_score", i), int'(bus.score), exp_score);
      chk_pos($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_vidas", i), int'(bus.vidas), 3);
      chk($sformatf("vec%0d_estado", i), int'(bus.estado), 1);
    end
    ship_far();

    // Score saturation
    while (exp_score < 999) begin
      ally_at(0, 0, 3);
      do_tick();
      exp_score++; exp_x = pred_x; exp_y = 20;
    end
    chk("sat_score", int'(bus.score), 999);
    chk_pos("sat");
    ally_at(0, 0, 3);
    do_tick();
    exp_x = pred_x; exp_y = 20;
    chk("sat_hold", int'(bus.score), 999);
    bus.raio_bola_aliada = '0;

    // start ignored while playing (on a non-tick cycle)
    @(negedge clk);
    while (m_cnt == 3) @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("ign_start_reinic", int'(bus.reiniciarJogo), 0);
    chk("ign_start_score", int'(bus.score), 999);
    chk("ign_start_estado", int'(bus.estado), 1);

    // Ship hit -> HIT for 3 ticks
    ship_on_enemy();
    do_tick();
    exp_vidas = 2; exp_x = pred_x; exp_y = 20;
    chk("hit_vidas", int'(bus.vidas), 2);
    chk("hit_estado", int'(bus.estado), 3);
    chk("hit_raio", int'(bus.raio_bola_inimiga), 0);
    chk_pos("hit");
    ship_far();
    repeat (2) do_tick();
    chk("hit2_estado", int'(bus.estado), 3);
    chk_pos("hit2");
    do_tick();
    chk("hit3_estado", int'(bus.estado), 1);
    chk("hit3_raio", int'(bus.raio_bola_inimiga), 5);
    chk_pos("hit3");

    // Ship and ally on the same tick
    ship_on_enemy();
    ally_at(0, 0, 3);
    do_tick();
    exp_x = pred_x; exp_y = 20;
    chk("both_vidas", int'(bus.vidas), 1);
    chk("both_score", int'(bus.score), 999);
    chk("both_estado", int'(bus.estado), 3);
    ship_far(); bus.raio_bola_aliada = '0;
    repeat (3) do_tick();
    chk("both_back", int'(bus.estado), 1);

    // Last life -> GAME_OVER, then restart
    ship_on_enemy();
    do_tick();
    chk("go_estado", int'(bus.estado), 4);
    chk("go_perdeu", int'(bus.perdeu), 1);
    chk("go_vidas", int'(bus.vidas), 0);
    chk("go_raio", int'(bus.raio_bola_inimiga), 0);
    ship_far();
    pulse_start();
    exp_x = pred_x; exp_y = 20; exp_score = 0;
    chk("re_perdeu", int'(bus.perdeu), 0);
    chk("re_vidas", int'(bus.vidas), 3);
    chk("re_score", int'(bus.score), 0);
    chk("re_reinic", int'(bus.reiniciarJogo), 1);
    chk("re_estado", int'(bus.estado), 1);
    chk_pos("re");

    // Pause freezes everything for 20 ticks
    do_tick();
    exp_y = 22;
    bus.pausa = 1'b1;
    @(posedge clk); #1;
    chk("pause_estado", int'(bus.estado), 2);
    repeat (20) do_tick();
    chk_pos("pause");
    chk("pause_score", int'(bus.score), 0);
    chk("pause_raio", int'(bus.raio_bola_inimiga), 5);
    chk("pause_estado20", int'(bus.estado), 2);
    bus.pausa = 1'b0;
    @(posedge clk); #1;
    chk("unpause_estado", int'(bus.estado), 1);
    do_tick();
    exp_y = 24;
    chk_pos("resume");

    // Asynchronous reset mid-game
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mrst_estado", int'(bus.estado), 0);
    chk("mrst_vidas", int'(bus.vidas), 3);
    chk("mrst_x", int'(bus.x_bola_inimiga), 0);
    chk("mrst_y", int'(bus.y_bola_inimiga), 20);
    chk("mrst_raio", int'(bus.raio_bola_inimiga), 0);
    chk("mrst_reinic", int'(bus.reiniciarJogo), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("mrst_hold_estado", int'(bus.estado), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
